// File: rtl/line_data_memory.sv
// Off-chip line memory model behind the data cache: fixed-latency 256-bit line reads/writes with a one-cycle ack.
// Optional read/write completion counters are built in when LINE_DATA_MEMORY_STATS_EN is defined.
module line_data_memory #(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 9,
  parameter int LINE_W     = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o
`ifdef LINE_DATA_MEMORY_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic                  w_enter_ack;
  logic                  w_accept;

  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_wr;
  logic [LINE_W-1:0]     r_wdata;
  logic [LINE_W-1:0]     r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [LINE_W-1:0]     r_rdata;

  logic [DEPTH_LOG2-1:0] w_idx_sel;
  logic                  w_wr_sel;
  logic [LINE_W-1:0]     w_wdata_sel;
  logic                  w_unused_addr;

  assign w_unused_addr = ^{mem_addr_i[31:DEPTH_LOG2+5], mem_addr_i[4:0]};

  // With LATENCY==1 the accepting edge also enters ACK, so the live inputs are used directly.
  assign w_idx_sel   = (r_state == IDLE) ? mem_addr_i[DEPTH_LOG2+4:5] : r_idx;
  assign w_wr_sel    = (r_state == IDLE) ? mem_write_i : r_wr;
  assign w_wdata_sel = (r_state == IDLE) ? mem_data_i : r_wdata;
  assign w_accept    = (r_state == IDLE) && mem_enable_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter_ack = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_enable_i) begin
          w_cnt_nxt = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_state_nxt = ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = ACK;
          w_enter_ack = 1'b1;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_idx   <= mem_addr_i[DEPTH_LOG2+4:5];
      r_wr    <= mem_write_i;
      r_wdata <= mem_data_i;
    end
  end

  // Reset on the commit edge must suppress the array write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_enter_ack && w_wr_sel) begin
      r_mem[w_idx_sel] <= w_wdata_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (w_enter_ack && !w_wr_sel) begin
      r_rdata <= r_mem[w_idx_sel];
    end
  end

  assign mem_ack_o  = (r_state == ACK);
  assign mem_data_o = r_rdata;

`ifdef LINE_DATA_MEMORY_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else if (w_enter_ack) begin
      if (w_wr_sel) r_wr_count <= sat_inc(r_wr_count);
      else          r_rd_count <= sat_inc(r_rd_count);
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`endif

endmodule
